// File: rtl/pixel_config_multi_if.sv
// pixel_config_multi_if: host/chip-side signal bundle for the pixel
// configuration engine; master drives the controls, slave is the engine.
interface pixel_config_multi_if #(
    parameter int NCH         = 4,
    parameter int DATA_WIDTH  = 15,
    parameter int DIV_WIDTH   = 6,
    parameter int FRAME_WIDTH = 10
);
    logic [DIV_WIDTH-1:0]      DIV;
    logic                      MSB_FIRST;
    logic [FRAME_WIDTH-1:0]    FRAME_LEN;
    logic [NCH*DATA_WIDTH-1:0] WR_DATA;
    logic                      WR_EN;
    logic                      START;
    logic                      BUSY;
    logic [NCH-1:0]            S_DIN;
    logic                      S_CLK;
    logic [NCH-1:0]            S_DATA;
    logic                      S_LOAD;
    logic                      FULL;
    logic                      EMPTY;
    logic [NCH*DATA_WIDTH-1:0] RB_DATA;
    logic                      RB_VALID;
    logic                      ACTIVE;
    logic                      DONE;
    logic                      UNDERFLOW;
    logic                      OVERFLOW;

    modport master (
        output DIV, MSB_FIRST, FRAME_LEN, WR_DATA, WR_EN,
        output START, BUSY, S_DIN,
        input  S_CLK, S_DATA, S_LOAD, FULL, EMPTY,
        input  RB_DATA, RB_VALID, ACTIVE, DONE,
        input  UNDERFLOW, OVERFLOW
    );

    modport slave (
        input  DIV, MSB_FIRST, FRAME_LEN, WR_DATA, WR_EN,
        input  START, BUSY, S_DIN,
        output S_CLK, S_DATA, S_LOAD, FULL, EMPTY,
        output RB_DATA, RB_VALID, ACTIVE, DONE,
        output UNDERFLOW, OVERFLOW
    );
endinterface

// File: rtl/pixel_config_multi.sv
// pixel_config_multi: FIFO-fed multi-channel serial shifter with a shared
// S_CLK, per-channel readback and a frame latch pulse.
module pixel_config_multi #(
    parameter int NCH         = 4,
    parameter int DATA_WIDTH  = 15,
    parameter int DIV_WIDTH   = 6,
    parameter int FIFO_AW     = 4,
    parameter int FRAME_WIDTH = 10
) (
    input logic SYS_CLK,
    input logic RESET,
    pixel_config_multi_if.slave bus
);
    localparam int CNT_W = 2 ** DIV_WIDTH;
    localparam int BW    = $clog2(DATA_WIDTH);
    localparam int W     = NCH * DATA_WIDTH;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, SHIFT_LO, SHIFT_HI, GAP, LATCH
    } state_t;

    state_t state, state_nx;

    logic [DIV_WIDTH-1:0]   div_q;
    logic                   msb_q;
    logic [FRAME_WIDTH-1:0] len_q;
    logic [FRAME_WIDTH-1:0] words;
    logic [CNT_W-1:0]       tick_cnt;
    logic [CNT_W-1:0]       tick_mask;
    logic                   tick;

    logic [W-1:0]   mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic full, empty, push, pop, start_ok, last_bit;

    logic [NCH-1:0][DATA_WIDTH-1:0] sh, rb_sh, rb_nx;
    logic [BW-1:0] bit_cnt;
    logic          lat_cnt;
    logic          rb_valid, done, underflow, overflow;
    logic [W-1:0]  rb_data;

    // Tick fires when the low DIV bits of the free counter are all ones.
    assign tick_mask = ~({CNT_W{1'b1}} << div_q);
    assign tick      = (tick_cnt & tick_mask) == tick_mask;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign start_ok = bus.START && (state == IDLE);
    assign pop      = (state == FETCH) && tick && !empty;
    assign push     = bus.WR_EN && (!full || pop);
    assign last_bit = bit_cnt == LAST_BIT;

    always_comb begin
        rb_nx = rb_sh;
        for (int k = 0; k < NCH; k++) begin
            rb_nx[k] = msb_q ?
                {rb_sh[k][DATA_WIDTH-2:0], bus.S_DIN[k]} :
                {bus.S_DIN[k], rb_sh[k][DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (bus.START) state_nx = FETCH;
            FETCH:
                if (tick) begin
                    if (!empty)           state_nx = SHIFT_LO;
                    else if (len_q == '0) state_nx = LATCH;
                    else                  state_nx = IDLE;
                end
            SHIFT_LO: if (tick) state_nx = SHIFT_HI;
            SHIFT_HI: if (tick) state_nx = last_bit ? GAP : SHIFT_LO;
            GAP:
                if (tick && !bus.BUSY)
                    state_nx = (len_q != '0 && words == len_q) ?
                               LATCH : FETCH;
            LATCH:    if (tick && lat_cnt) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.S_CLK  = state == SHIFT_HI;
        bus.S_LOAD = state == LATCH;
        bus.ACTIVE = state != IDLE;
        bus.S_DATA = '0;
        if (state == SHIFT_LO || state == SHIFT_HI)
            for (int k = 0; k < NCH; k++)
                bus.S_DATA[k] = msb_q ? sh[k][DATA_WIDTH-1] : sh[k][0];
    end

    always_ff @(posedge SYS_CLK) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= bus.WR_DATA;
    end

    always_ff @(posedge SYS_CLK or negedge RESET) begin
        if (!RESET) begin
            div_q     <= '0;
            msb_q     <= 1'b0;
            len_q     <= '0;
            words     <= '0;
            tick_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sh        <= '0;
            rb_sh     <= '0;
            bit_cnt   <= '0;
            lat_cnt   <= 1'b0;
            rb_data   <= '0;
            rb_valid  <= 1'b0;
            done      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= start_ok ? '0 : tick_cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (bus.WR_EN && !push) overflow <= 1'b1;
            if (start_ok) begin
                div_q     <= bus.DIV;
                msb_q     <= bus.MSB_FIRST;
                len_q     <= bus.FRAME_LEN;
                words     <= '0;
                underflow <= 1'b0;
                overflow  <= 1'b0;
            end
            if (pop) begin
                sh      <= mem[rd_ptr[FIFO_AW-1:0]];
                bit_cnt <= '0;
            end
            if (state == FETCH && tick && empty &&
                len_q != '0 && words < len_q)
                underflow <= 1'b1;
            if (state == SHIFT_HI && tick) begin
                rb_sh   <= rb_nx;
                bit_cnt <= bit_cnt + 1'b1;
                for (int k = 0; k < NCH; k++)
                    sh[k] <= msb_q ? (sh[k] << 1) : (sh[k] >> 1);
                if (last_bit) begin
                    rb_data  <= rb_nx;
                    rb_valid <= 1'b1;
                    words    <= words + 1'b1;
                end
            end
            lat_cnt <= (state == LATCH) ? (lat_cnt | tick) : 1'b0;
            if (state == LATCH && tick && lat_cnt) done <= 1'b1;
        end
    end

    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.RB_DATA   = rb_data;
    assign bus.RB_VALID  = rb_valid;
    assign bus.DONE      = done;
    assign bus.UNDERFLOW = underflow;
    assign bus.OVERFLOW  = overflow;
endmodule

// File: tb/tb_pixel_config_multi.sv
// tb_pixel_config_multi: directed table-driven bench with a loopback chip
// model that returns each word one word later on S_DIN.
module tb_pixel_config_multi;
    localparam int NCH = 4;
    localparam int DW  = 15;
    localparam int DVW = 6;
    localparam int AW  = 4;
    localparam int FW  = 10;
    localparam int W   = NCH * DW;

    typedef struct {
        int div;
        int msb;
        int len;
        int nw;
        int edges;
        int loads;
        int dones;
        int uf;
        int phase;
        int rbv;
        logic [DW-1:0] ch0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_config_multi_if #(
        .NCH(NCH), .DATA_WIDTH(DW), .DIV_WIDTH(DVW), .FRAME_WIDTH(FW)
    ) bus ();

    pixel_config_multi #(
        .NCH(NCH), .DATA_WIDTH(DW), .DIV_WIDTH(DVW),
        .FIFO_AW(AW), .FRAME_WIDTH(FW)
    ) dut (
        .SYS_CLK(clk),
        .RESET(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int rises, falls, loads, dones, hi_run, last_hi;
    logic ch0_q[$];
    logic [W-1:0] rb_q[$];
    logic [DW:0] chip [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_din
        assign bus.S_DIN[k] = chip[k][DW];
    end

    always @(posedge bus.S_CLK) begin
        rises++;
        ch0_q.push_back(bus.S_DATA[0]);
        for (int k = 0; k < NCH; k++)
            chip[k] = {chip[k][DW-1:0], bus.S_DATA[k]};
    end

    always @(negedge bus.S_CLK) falls++;

    always @(negedge clk) begin
        if (bus.S_LOAD) loads++;
        if (bus.DONE) dones++;
        if (bus.RB_VALID) rb_q.push_back(bus.RB_DATA);
        if (bus.S_CLK) hi_run++;
        else if (hi_run > 0) begin
            last_hi = hi_run;
            hi_run = 0;
        end
    end

    function automatic logic [DW-1:0] mk_ch(input int w, input int k);
        logic [DW-1:0] v;
        v = 15'h5A5A ^ DW'(w * 3855) ^ DW'(k * 4369);
        return v;
    endfunction

    function automatic logic [W-1:0] mk_word(input int w);
        logic [W-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*DW +: DW] = mk_ch(w, k);
        return v;
    endfunction

    function automatic logic [DW-1:0] ch0_word(input int start);
        logic [DW-1:0] v;
        v = '0;
        for (int i = start; i < start + DW && i < ch0_q.size(); i++)
            v = {v[DW-2:0], ch0_q[i]};
        return v;
    endfunction

    function automatic logic [12:0] ctl();
        return {bus.S_CLK, bus.S_LOAD, bus.ACTIVE, bus.DONE,
                bus.UNDERFLOW, bus.OVERFLOW, bus.RB_VALID,
                bus.FULL, bus.EMPTY, bus.S_DATA};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rises = 0; falls = 0; loads = 0; dones = 0;
        hi_run = 0; last_hi = 0;
        ch0_q.delete();
        rb_q.delete();
        for (int k = 0; k < NCH; k++) chip[k] = '0;
    endtask

    task automatic write_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.WR_DATA = mk_word(base + i);
            bus.WR_EN = 1'b1;
        end
        @(negedge clk);
        bus.WR_EN = 1'b0;
    endtask

    task automatic start_frame(input int div, input int msb, input int len);
        bus.DIV = DVW'(div);
        bus.MSB_FIRST = msb[0];
        bus.FRAME_LEN = FW'(len);
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.ACTIVE && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.ACTIVE, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t tbl[5];
        int n, hi, r0;
        tbl[0] = '{0, 1, 2, 2, 60, 2, 1, 0, 1, 2, 15'h5A5A};
        tbl[1] = '{2, 0, 2, 2, 60, 8, 1, 0, 4, 2, 15'h2D2D};
        tbl[2] = '{0, 1, 3, 1, 30, 0, 0, 1, 1, 1, 15'h5A5A};
        tbl[3] = '{0, 1, 0, 0,  0, 2, 1, 0, 0, 0, 15'h0000};
        tbl[4] = '{1, 1, 0, 3, 90, 4, 1, 0, 2, 3, 15'h5A5A};

        bus.DIV = '0; bus.MSB_FIRST = 1'b1; bus.FRAME_LEN = '0;
        bus.WR_DATA = '0; bus.WR_EN = 1'b0;
        bus.START = 1'b0; bus.BUSY = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_ctl", ctl(), {9'b000000001, 4'b0000});
        check("reset_rb", bus.RB_DATA, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // BUSY held in GAP
        clear_mon();
        write_words(0, 2);
        start_frame(0, 1, 2);
        n = 0;
        while (!bus.RB_VALID && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_gap_reached", bus.RB_VALID, 1);
        bus.BUSY = 1'b1;
        hi = 0;
        r0 = rises;
        repeat (10) begin
            @(negedge clk);
            if (bus.S_CLK) hi++;
        end
        check("busy_sclk_static", hi, 0);
        check("busy_no_edge", rises - r0, 0);
        check("busy_active", bus.ACTIVE, 1);
        bus.BUSY = 1'b0;
        wait_idle("busy_end");
        check("busy_edges", rises + falls, 60);
        check("busy_done", dones, 1);

        // reset asserted mid-shift
        clear_mon();
        write_words(0, 2);
        start_frame(2, 1, 2);
        n = 0;
        while (!bus.S_CLK && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_in_shift", bus.S_CLK, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", ctl(), {9'b000000001, 4'b0000});
        check("rst_mid_rb", bus.RB_DATA, 0);
        check("rst_mid_noload", loads, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            clear_mon();
            write_words(0, tbl[i].nw);
            start_frame(tbl[i].div, tbl[i].msb, tbl[i].len);
            wait_idle($sformatf("v%0d_timeout", i));
            check($sformatf("v%0d_edges", i), rises + falls, tbl[i].edges);
            check($sformatf("v%0d_loads", i), loads, tbl[i].loads);
            check($sformatf("v%0d_done", i), dones, tbl[i].dones);
            check($sformatf("v%0d_underflow", i), bus.UNDERFLOW, tbl[i].uf);
            check($sformatf("v%0d_phase", i), last_hi, tbl[i].phase);
            check($sformatf("v%0d_rbv", i), rb_q.size(), tbl[i].rbv);
            check($sformatf("v%0d_ch0", i), ch0_word(0), tbl[i].ch0);
            if (tbl[i].nw >= 1)
                check($sformatf("v%0d_rb1", i), rb_q[0], 0);
            if (tbl[i].nw >= 2)
                check($sformatf("v%0d_rb2", i), rb_q[1], mk_word(0));
        end

        // FIFO overflow: 17th word is dropped
        clear_mon();
        write_words(100, 17);
        check("ovf_full", bus.FULL, 1);
        check("ovf_flag", bus.OVERFLOW, 1);
        start_frame(0, 1, 0);
        check("ovf_cleared", bus.OVERFLOW, 0);
        wait_idle("ovf_timeout");
        check("ovf_rbv", rb_q.size(), 16);
        check("ovf_edges", rises + falls, 480);
        check("ovf_last_ch0", ch0_word(ch0_q.size() - DW), mk_ch(115, 0));
        check("ovf_last_rb", rb_q[15], mk_word(114));
        check("ovf_empty", bus.EMPTY, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
